// File: rtl/pattern_pkg.sv
// Shared types and limits for the serial pattern detector.
//   ctrl_state_t : control FSM states (S_IDLE until the first pattern load, then S_RUN)
//   PAT_W_MAX    : largest supported pattern length
package pattern_pkg;

    localparam int unsigned PAT_W_MAX = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } ctrl_state_t;

endpackage : pattern_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears q
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one; holds at all-ones
//   q     : counter value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Q_MAX = '1;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != Q_MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable WIDTH-bit pattern and
// selectable overlapping / non-overlapping matching.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   load        : capture pattern_in, restart detection (wins over valid)
//   pattern_in  : new pattern, bit WIDTH-1 is the first bit received
//   overlap     : 1 = overlapping matches, 0 = history restarts after a match
//   valid       : a carries a new bit this cycle
//   a           : serial data bit
//   y           : Mealy match strobe (combinational)
//   y_q         : y delayed by one clock
//   armed       : a pattern has been loaded
//   match_count : saturating number of matches since the last load
module pattern_detector
    import pattern_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             overlap,
    input  logic             valid,
    input  logic             a,
    output logic             y,
    output logic             y_q,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned HIST_W = WIDTH - 1;
    localparam int unsigned FILL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);

    // Reject unsupported pattern lengths at elaboration.
    if ((WIDTH < 2) || (WIDTH > PAT_W_MAX)) begin : g_bad_width
        $fatal(1, "pattern_detector: WIDTH must be within 2..PAT_W_MAX");
    end

    ctrl_state_t       state_q, state_d;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIDTH-1:0]  window;

    // Candidate window: stored history with the current bit appended as LSB.
    assign window = {hist_q, a};
    assign armed  = (state_q == S_RUN);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y;
        end
    end

    // Next-state, history shift and Mealy match.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        y       = 1'b0;

        case (state_q)
            S_IDLE:  if (load) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            // The bit presented alongside a load is dropped.
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
        end else if ((state_q == S_RUN) && valid) begin
            y      = (fill_q == FILL_MAX) && (window == pat_q);
            hist_d = window[HIST_W-1:0];
            // Non-overlap restarts the fill count; stale history is refilled before use.
            if (y && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .inc   (y),
        .q     (match_count)
    );

endmodule : pattern_detector

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: directed scenarios plus a
// randomized run against a queue-based reference model. Two instances share
// the inputs: one with an 8-bit counter, one with a 2-bit counter.
module tb_pattern_detector;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] pattern_in;
    logic             overlap;
    logic             valid;
    logic             a;
    logic             y, y_q, armed;
    logic [7:0]       match_count;
    logic             y2, y_q2, armed2;
    logic [1:0]       cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    pattern_detector #(.WIDTH(WIDTH), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .valid(valid), .a(a),
        .y(y), .y_q(y_q), .armed(armed), .match_count(match_count)
    );

    pattern_detector #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .valid(valid), .a(a),
        .y(y2), .y_q(y_q2), .armed(armed2), .match_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits received since the last restart, newest at the back.
    bit             m_loaded;
    bit [WIDTH-1:0] m_pat;
    bit             m_q[$];
    int             m_cnt8;
    int             m_cnt2;
    bit             m_yq;

    // Observations from the most recent cycle.
    bit         exp_y;
    logic       obs_y, obs_y2, obs_yq, obs_armed;
    logic [7:0] obs_cnt;
    logic [1:0] obs_cnt2;

    function automatic bit model_match(input bit av);
        int base;
        if (m_q.size() < WIDTH - 1) return 1'b0;
        base = m_q.size() - (WIDTH - 1);
        for (int i = 0; i < WIDTH - 1; i++)
            if (m_q[base + i] != m_pat[WIDTH - 1 - i]) return 1'b0;
        return av == m_pat[0];
    endfunction

    task automatic model_reset();
        m_loaded = 1'b0;
        m_pat    = '0;
        m_q.delete();
        m_cnt8   = 0;
        m_cnt2   = 0;
        m_yq     = 1'b0;
    endtask

    task automatic model_commit(input bit ld, input bit [WIDTH-1:0] pv, input bit ov,
                                input bit vl, input bit av, input bit hit);
        if (ld) begin
            m_loaded = 1'b1;
            m_pat    = pv;
            m_q.delete();
            m_cnt8   = 0;
            m_cnt2   = 0;
        end else if (vl && m_loaded) begin
            m_q.push_back(av);
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
                if (!ov) m_q.delete();
            end
            while (m_q.size() > WIDTH - 1) void'(m_q.pop_front());
        end
        m_yq = hit;
    endtask

    // One clock: drive at negedge, sample y before the edge, registered outputs after.
    task automatic cycle(input bit ld, input bit [WIDTH-1:0] pv, input bit ov,
                         input bit vl, input bit av);
        @(negedge clk);
        load = ld; pattern_in = pv; overlap = ov; valid = vl; a = av;
        #1;
        exp_y  = vl && !ld && m_loaded && model_match(av);
        obs_y  = y;
        obs_y2 = y2;
        @(posedge clk);
        #1;
        model_commit(ld, pv, ov, vl, av, exp_y);
        obs_yq    = y_q;
        obs_cnt   = match_count;
        obs_cnt2  = cnt2;
        obs_armed = armed;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++; if (y_q !== 1'b0) $display("FAIL reset_yq got %b want 0", y_q); else n_pass++;
        n_checks++; if (armed !== 1'b0) $display("FAIL reset_armed got %b want 0", armed); else n_pass++;
        n_checks++; if (match_count !== 8'd0) $display("FAIL reset_cnt got %0d want 0", match_count); else n_pass++;
        n_checks++; if (cnt2 !== 2'd0) $display("FAIL reset_cnt2 got %0d want 0", cnt2); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
            n_checks++; if (obs_y !== 1'b0) $display("FAIL idle_y bit %0d got %b want 0", i, obs_y); else n_pass++;
            n_checks++; if (obs_armed !== 1'b0) $display("FAIL idle_armed bit %0d got %b want 0", i, obs_armed); else n_pass++;
        end
        n_checks++; if (obs_cnt !== 8'd0) $display("FAIL idle_cnt got %0d want 0", obs_cnt); else n_pass++;
    endtask

    task automatic test_overlap();
        bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit want[7] = '{0, 0, 0, 1, 0, 0, 1};
        cycle(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        n_checks++; if (obs_armed !== 1'b1) $display("FAIL ovl_armed got %b want 1", obs_armed); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, bits[i]);
            n_checks++; if (obs_y !== want[i]) $display("FAIL ovl_y bit %0d got %b want %b", i + 1, obs_y, want[i]); else n_pass++;
            n_checks++; if (obs_yq !== want[i]) $display("FAIL ovl_yq bit %0d got %b want %b", i + 1, obs_yq, want[i]); else n_pass++;
        end
        n_checks++; if (obs_cnt !== 8'd2) $display("FAIL ovl_cnt got %0d want 2", obs_cnt); else n_pass++;
    endtask

    task automatic test_nonoverlap();
        bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit want[7] = '{0, 0, 0, 1, 0, 0, 0};
        cycle(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 4'b0000, 1'b0, 1'b1, bits[i]);
            n_checks++; if (obs_y !== want[i]) $display("FAIL novl_y bit %0d got %b want %b", i + 1, obs_y, want[i]); else n_pass++;
        end
        n_checks++; if (obs_cnt !== 8'd1) $display("FAIL novl_cnt got %0d want 1", obs_cnt); else n_pass++;
    endtask

    task automatic test_reload();
        bit pre[3]  = '{1, 0, 1};
        bit post[5] = '{1, 0, 0, 0, 0};
        bit want[5] = '{0, 0, 0, 0, 1};
        cycle(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 1'b1, 1'b1, pre[i]);
        // The bit offered with the load would complete 1011 and must be dropped.
        cycle(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        n_checks++; if (obs_y !== 1'b0) $display("FAIL reload_load_y got %b want 0", obs_y); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, post[i]);
            n_checks++; if (obs_y !== want[i]) $display("FAIL reload_y bit %0d got %b want %b", i + 1, obs_y, want[i]); else n_pass++;
        end
        n_checks++; if (obs_cnt !== 8'd1) $display("FAIL reload_cnt got %0d want 1", obs_cnt); else n_pass++;
    endtask

    task automatic test_valid_gaps();
        bit bits[4] = '{1, 0, 1, 1};
        bit want[4] = '{0, 0, 0, 1};
        cycle(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, bits[i]);
            n_checks++; if (obs_y !== want[i]) $display("FAIL gap_y bit %0d got %b want %b", i + 1, obs_y, want[i]); else n_pass++;
            for (int g = 0; g < 3; g++) begin
                cycle(1'b0, 4'b0000, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
                n_checks++; if (obs_y !== 1'b0) $display("FAIL gap_idle_y bit %0d gap %0d got %b want 0", i + 1, g, obs_y); else n_pass++;
            end
        end
        n_checks++; if (obs_yq !== 1'b0) $display("FAIL gap_yq got %b want 0", obs_yq); else n_pass++;
        n_checks++; if (obs_cnt !== 8'd1) $display("FAIL gap_cnt got %0d want 1", obs_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        int hits = 0;
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
            n_checks++; if (obs_y2 !== (i >= 3)) $display("FAIL sat_y bit %0d got %b want %b", i + 1, obs_y2, (i >= 3)); else n_pass++;
            if (obs_y2 === 1'b1) hits++;
        end
        n_checks++; if (hits != 7) $display("FAIL sat_hits got %0d want 7", hits); else n_pass++;
        n_checks++; if (obs_cnt2 !== 2'd3) $display("FAIL sat_cnt2 got %0d want 3", obs_cnt2); else n_pass++;
        n_checks++; if (obs_cnt !== 8'd7) $display("FAIL sat_cnt8 got %0d want 7", obs_cnt); else n_pass++;
        // Asynchronous reset mid-cycle while the stream is still matching.
        valid = 1'b1; a = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (y !== 1'b0) $display("FAIL arst_y got %b want 0", y); else n_pass++;
        n_checks++; if (y_q !== 1'b0) $display("FAIL arst_yq got %b want 0", y_q); else n_pass++;
        n_checks++; if (armed !== 1'b0) $display("FAIL arst_armed got %b want 0", armed); else n_pass++;
        n_checks++; if (match_count !== 8'd0) $display("FAIL arst_cnt got %0d want 0", match_count); else n_pass++;
        n_checks++; if (cnt2 !== 2'd0) $display("FAIL arst_cnt2 got %0d want 0", cnt2); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
            n_checks++; if (obs_y !== 1'b0) $display("FAIL arst_noload_y bit %0d got %b want 0", i + 1, obs_y); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit             ld, ov, vl, av;
        bit [WIDTH-1:0] pv;
        cycle(1'b1, 4'($urandom), 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            ld = ($urandom_range(0, 63) == 0);
            pv = 4'($urandom);
            ov = 1'($urandom_range(0, 1));
            vl = ($urandom_range(0, 3) != 0);
            av = 1'($urandom_range(0, 1));
            cycle(ld, pv, ov, vl, av);
            n_checks++; if (obs_y !== exp_y) $display("FAIL rand_y cycle %0d got %b want %b", c, obs_y, exp_y); else n_pass++;
            n_checks++; if (obs_yq !== m_yq) $display("FAIL rand_yq cycle %0d got %b want %b", c, obs_yq, m_yq); else n_pass++;
            n_checks++; if (obs_cnt !== 8'(m_cnt8)) $display("FAIL rand_cnt cycle %0d got %0d want %0d", c, obs_cnt, m_cnt8); else n_pass++;
            n_checks++; if (obs_cnt2 !== 2'(m_cnt2)) $display("FAIL rand_cnt2 cycle %0d got %0d want %0d", c, obs_cnt2, m_cnt2); else n_pass++;
            n_checks++; if (obs_armed !== m_loaded) $display("FAIL rand_armed cycle %0d got %b want %b", c, obs_armed, m_loaded); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; pattern_in = '0; overlap = 1'b0; valid = 1'b0; a = 1'b0;
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_reload();
        test_valid_gaps();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pattern_detector
